// File: rtl/gray_arb_pkg.sv
// Shared types and constants for the gray-code adder arbiter slice.
package gray_arb_pkg;

    localparam int GAA_WIDTH = 4;
    localparam int GAA_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } gaa_state_t;

    // A single requester still needs a 1-bit id so the ports stay legal.
    function automatic int gaa_idw(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/gray_adder_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module rr_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NREQ = GAA_NREQ,
    localparam int IDW = gaa_idw(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    logic found;
    int   j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_i) + i) % NREQ;
            if (en_i && !found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/gray_code_adder_sv.sv
// Combinational gray-code adder: gray operands in, gray sum and binary carry-out.
module gray_code_adder_sv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o
);

    logic [WIDTH-1:0] a_bin;
    logic [WIDTH-1:0] b_bin;
    logic [WIDTH-1:0] s_bin;

    always_comb begin
        a_bin[WIDTH-1] = a_i[WIDTH-1];
        b_bin[WIDTH-1] = b_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            a_bin[i] = a_bin[i+1] ^ a_i[i];
            b_bin[i] = b_bin[i+1] ^ b_i[i];
        end
        {co_o, s_bin} = {1'b0, a_bin} + {1'b0, b_bin} + {{WIDTH{1'b0}}, ci_i};
        sum_o = s_bin ^ (s_bin >> 1);
    end

endmodule

// File: rtl/gray_adder_arbiter.sv
// Shares one gray-code adder among NREQ requesters: round-robin grant, registered
// operands, one in-flight op, and a single valid/ready response port.
module gray_adder_arbiter
    import gray_arb_pkg::*;
#(
    parameter int WIDTH = GAA_WIDTH,
    parameter int NREQ  = GAA_NREQ,
    localparam int IDW  = gaa_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ci,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_co,
    output logic [IDW-1:0]        rsp_id,
    output logic [1:0]            dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and the sender holds its payload until then.
    gaa_state_t       state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ci_q;
    logic [IDW-1:0]   id_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_co_q;
    logic [IDW-1:0]   rsp_id_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_ci;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (state_q == IDLE),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    gray_code_adder_sv #(.WIDTH(WIDTH)) u_add (
        .a_i   (a_q),
        .b_i   (b_q),
        .ci_i  (ci_q),
        .sum_o (add_sum),
        .co_o  (add_co)
    );

    // Only the winner's lanes are read, so X on other requesters never reaches a register.
    always_comb begin
        accept = |(req_valid & grant);
        sel_a  = req_a[int'(win_idx)*WIDTH +: WIDTH];
        sel_b  = req_b[int'(win_idx)*WIDTH +: WIDTH];
        sel_ci = req_ci[win_idx];
        ptr_d  = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ci_q        <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_co_q    <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        ci_q    <= sel_ci;
                        id_q    <= win_idx;
                        ptr_q   <= ptr_d;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_q   <= add_sum;
                    rsp_co_q    <= add_co;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_id    = rsp_id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_adder_arbiter.sv
// Directed bench for gray_adder_arbiter: single ops, overflow, carry-in, rotation,
// backpressure and mid-operation reset, with hand-computed expected values.
module tb_gray_adder_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ci;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_co;
    logic [1:0]            rsp_id;
    logic [1:0]            dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    // Expected responses as {id, co, sum}, and expected grant order.
    logic [6:0] exp_q[$];
    logic [1:0] gexp_q[$];

    gray_adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_co    (rsp_co),
        .rsp_id    (rsp_id),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic set_req(input int r, input logic [3:0] a, input logic [3:0] b, input logic ci);
        req_a[r*WIDTH +: WIDTH] = a;
        req_b[r*WIDTH +: WIDTH] = b;
        req_ci[r]               = ci;
    endtask

    task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b, input logic ci,
                          output logic [3:0] sum, output logic co, output logic [1:0] id);
        int t;
        sum = 'x;
        co  = 1'bx;
        id  = 'x;
        set_req(r, a, b, ci);
        req_valid[r] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[r] && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        check("op_grant", {31'd0, req_ready[r]}, 32'd1);
        if (req_ready[r]) begin
            @(posedge clk); #1;
            req_valid[r] = 1'b0;
            t = 0;
            while (!rsp_valid && t < 10) begin
                @(posedge clk); #1;
                t++;
            end
            check("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            sum = rsp_sum;
            co  = rsp_co;
            id  = rsp_id;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        req_valid[r] = 1'b0;
    endtask

    initial begin
        logic [3:0] s;
        logic       c;
        logic [1:0] id;
        logic [6:0] exp_v;
        logic [1:0] g_idx;
        int         got;
        int         gcount;
        int         onehot_bad;
        int         cyc;

        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_sum", {28'd0, rsp_sum}, 32'd0);
        check("rst_co", {31'd0, rsp_co}, 32'd0);
        check("rst_id", {30'd0, rsp_id}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: single op on req0, latency check (3 + 1 = 4 -> 2 + 1 = 3 ... gray 0011 + 0001 = 0010)
        set_req(0, 4'b0011, 4'b0001, 1'b0);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", {28'd0, req_ready}, 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        check("t1_calc_state", {30'd0, dbg_state}, 32'd1);
        check("t1_calc_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("t1_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_sum", {28'd0, rsp_sum}, 32'b0010);
        check("t1_co", {31'd0, rsp_co}, 32'd0);
        check("t1_id", {30'd0, rsp_id}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("t1_drop", {31'd0, rsp_valid}, 32'd0);

        // 2: overflow 15 + 1 on req1
        run_op(1, 4'b1000, 4'b0001, 1'b0, s, c, id);
        check("t2_sum", {28'd0, s}, 32'b0000);
        check("t2_co", {31'd0, c}, 32'd1);
        check("t2_id", {30'd0, id}, 32'd1);

        // 3: carry-in only on req2
        run_op(2, 4'b0000, 4'b0000, 1'b1, s, c, id);
        check("t3_sum", {28'd0, s}, 32'b0001);
        check("t3_co", {31'd0, c}, 32'd0);
        check("t3_id", {30'd0, id}, 32'd2);

        // 5: backpressure on req3 (6 + 7 = 13 -> gray 1011); req1 waits meanwhile
        set_req(3, 4'b0101, 4'b0100, 1'b0);
        req_valid = 4'b1000;
        #1;
        check("t5_ready", {28'd0, req_ready}, 32'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            check("t5_valid_hold", {31'd0, rsp_valid}, 32'd1);
            check("t5_sum_hold", {28'd0, rsp_sum}, 32'b1011);
            check("t5_co_hold", {31'd0, rsp_co}, 32'd0);
            check("t5_id_hold", {30'd0, rsp_id}, 32'd3);
            check("t5_no_ready", {28'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        check("t5_valid_pre", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("t5_complete", {31'd0, rsp_valid}, 32'd0);

        // 4: all requesters valid, rotation from pointer 0
        set_req(0, 4'b0001, 4'b0001, 1'b0);
        set_req(1, 4'b0011, 4'b0010, 1'b1);
        set_req(2, 4'b0110, 4'b0111, 1'b0);
        set_req(3, 4'b1100, 4'b1100, 1'b1);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({2'd0, 1'b0, 4'b0011});
            exp_q.push_back({2'd1, 1'b0, 4'b0101});
            if (k == 0) begin
                exp_q.push_back({2'd2, 1'b0, 4'b1101});
                exp_q.push_back({2'd3, 1'b1, 4'b0001});
            end
        end
        gexp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        got = 0;
        gcount = 0;
        onehot_bad = 0;
        cyc = 0;
        #1;
        while (got < 6 && cyc < 40) begin
            if ($countones(req_ready) > 1) onehot_bad++;
            if (req_ready != '0 && gcount < 6) begin
                g_idx = '0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_idx = 2'(i);
                check("t4_grant", {30'd0, g_idx}, {30'd0, gexp_q.pop_front()});
                gcount++;
            end
            if (rsp_valid) begin
                exp_v = exp_q.pop_front();
                check("t4_rsp", {25'd0, rsp_id, rsp_co, rsp_sum}, {25'd0, exp_v});
                got++;
                if (got == 6) req_valid = '0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rsp_ready = 1'b0;
        check("t4_rsp_count", got, 32'd6);
        check("t4_onehot", onehot_bad, 32'd0);

        // 6: reset during CALC after granting req2 (pointer is 2 here)
        set_req(2, 4'b0001, 4'b0001, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("t6_ready", {28'd0, req_ready}, 32'b0100);
        @(posedge clk); #1;
        check("t6_calc", {30'd0, dbg_state}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_state", {30'd0, dbg_state}, 32'd0);
        check("t6_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_rst_sum", {28'd0, rsp_sum}, 32'd0);
        check("t6_rst_id", {30'd0, rsp_id}, 32'd0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk); #1;
        check("t6_still_idle", {31'd0, rsp_valid}, 32'd0);
        set_req(1, 4'b0010, 4'b0001, 1'b0);
        req_valid = 4'b0110;
        reset_n = 1'b1;
        #1;
        check("t6_ptr0_grant", {28'd0, req_ready}, 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t6_rsp_id", {30'd0, rsp_id}, 32'd1);
        check("t6_rsp_sum", {28'd0, rsp_sum}, 32'b0110);
        check("t6_rsp_co", {31'd0, rsp_co}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("t6_done", {31'd0, rsp_valid}, 32'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
